generador_conmutacion: RTL and testbench

GENERADOR_CONMUTACION -- requirements
Module: generador_conmutacion

---
 rtl/generador_conmutacion.sv | 168 ++++++++++++++++
 tb/tb_generador_conmutacion.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/generador_conmutacion.sv
// generador_conmutacion: PWM-style switching-signal generator feeding a
// two-way output demux, with safe channel changeover.
//
// Optional feature macro: GENERADOR_TIEMPO_MUERTO_EN
//   defined   -> changeover inserts TIEMPO_MUERTO forced-low cycles (MUERTO state)
//   undefined -> changeover happens at the wrap edge with one forced-low cycle
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   enable              1 = generate, 0 = idle
//   duty                high cycles per period
//   periodo             period length minus one
//   sel_req             requested output channel
//   signal_conmutacion  registered switching signal (demux data)
//   select_salida       registered channel select (demux select)
//   cambio_en_curso     high while a changeover is in progress
//   fin_periodo         one-cycle pulse after the last cycle of each period
module generador_conmutacion #(
    parameter int unsigned ANCHO         = 8,
    parameter int unsigned TIEMPO_MUERTO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ANCHO-1:0] duty,
    input  logic [ANCHO-1:0] periodo,
    input  logic             sel_req,
    output logic             signal_conmutacion,
    output logic             select_salida,
    output logic             cambio_en_curso,
    output logic             fin_periodo
);

    // Elaboration-time range guard for the dead-time length
    if ((TIEMPO_MUERTO < 1) || (TIEMPO_MUERTO > 255)) begin : g_rango_tiempo_muerto
        $error("TIEMPO_MUERTO must be in 1..255");
    end

    logic [ANCHO-1:0] cnt;
    logic [ANCHO-1:0] cnt_next;
    logic [ANCHO-1:0] duty_sh;
    logic [ANCHO-1:0] duty_sh_next;
    logic [ANCHO-1:0] periodo_sh;
    logic [ANCHO-1:0] periodo_sh_next;
    logic             primer_ciclo;
    logic             en_c;
    logic             wrap_c;
    logic             sig_next;
    logic             sel_next;
    logic             fin_next;
    logic             cambio_next;

`ifdef GENERADOR_TIEMPO_MUERTO_EN
    localparam int unsigned DEAD_W = 8;

    typedef enum logic {
        RUN    = 1'b0,
        MUERTO = 1'b1
    } estado_t;

    estado_t           estado;
    estado_t           estado_next;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_cnt_next;
    logic              sel_lat;
    logic              sel_lat_next;
`endif

    // Next-state and output logic
    always_comb begin
        cnt_next        = cnt;
        duty_sh_next    = duty_sh;
        periodo_sh_next = periodo_sh;
        sig_next        = 1'b0;
        sel_next        = select_salida;
        fin_next        = 1'b0;
        cambio_next     = 1'b0;
`ifdef GENERADOR_TIEMPO_MUERTO_EN
        estado_next     = estado;
        dead_cnt_next   = dead_cnt;
        sel_lat_next    = sel_lat;
`endif

        // The first cycle after reset is treated as idle so the first period
        // starts from freshly shadowed duty/periodo, like an enable rise.
        en_c   = enable && !primer_ciclo;
        wrap_c = en_c && (cnt == periodo_sh);
`ifdef GENERADOR_TIEMPO_MUERTO_EN
        wrap_c = wrap_c && (estado == RUN);
`endif

        // Shadow registers only move at period boundaries or while idle
        if (!en_c || wrap_c) begin
            duty_sh_next    = duty;
            periodo_sh_next = periodo;
        end

`ifdef GENERADOR_TIEMPO_MUERTO_EN
        if (estado == MUERTO) begin
            // Line held low; select switches only on the final dead cycle
            cnt_next = '0;
            if (dead_cnt == DEAD_W'(TIEMPO_MUERTO - 1)) begin
                estado_next   = RUN;
                dead_cnt_next = '0;
                sel_next      = sel_lat;
            end else begin
                dead_cnt_next = dead_cnt + DEAD_W'(1);
                cambio_next   = 1'b1;
            end
        end else
`endif
        if (!en_c) begin
            // Idle line: select may track the request directly
            cnt_next = '0;
            sel_next = sel_req;
        end else begin
            sig_next = (cnt < duty_sh);
            fin_next = wrap_c;
            cnt_next = wrap_c ? '0 : cnt + ANCHO'(1);
            if (wrap_c && (sel_req != select_salida)) begin
                sig_next = 1'b0;
`ifdef GENERADOR_TIEMPO_MUERTO_EN
                estado_next   = MUERTO;
                sel_lat_next  = sel_req;
                dead_cnt_next = '0;
                cambio_next   = 1'b1;
`else
                sel_next      = sel_req;
`endif
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                <= '0;
            duty_sh            <= '0;
            periodo_sh         <= '0;
            primer_ciclo       <= 1'b1;
            signal_conmutacion <= 1'b0;
            select_salida      <= 1'b0;
            cambio_en_curso    <= 1'b0;
            fin_periodo        <= 1'b0;
`ifdef GENERADOR_TIEMPO_MUERTO_EN
            estado             <= RUN;
            dead_cnt           <= '0;
            sel_lat            <= 1'b0;
`endif
        end else begin
            cnt                <= cnt_next;
            duty_sh            <= duty_sh_next;
            periodo_sh         <= periodo_sh_next;
            primer_ciclo       <= 1'b0;
            signal_conmutacion <= sig_next;
            select_salida      <= sel_next;
            cambio_en_curso    <= cambio_next;
            fin_periodo        <= fin_next;
`ifdef GENERADOR_TIEMPO_MUERTO_EN
            estado             <= estado_next;
            dead_cnt           <= dead_cnt_next;
            sel_lat            <= sel_lat_next;
`endif
        end
    end

endmodule

// File: tb/tb_generador_conmutacion.sv
// Directed self-checking bench for generador_conmutacion (default parameters).
module tb_generador_conmutacion;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] duty;
    logic [7:0] periodo;
    logic       sel_req;
    logic       signal_conmutacion;
    logic       select_salida;
    logic       cambio_en_curso;
    logic       fin_periodo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generador_conmutacion dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .duty               (duty),
        .periodo            (periodo),
        .sel_req            (sel_req),
        .signal_conmutacion (signal_conmutacion),
        .select_salida      (select_salida),
        .cambio_en_curso    (cambio_en_curso),
        .fin_periodo        (fin_periodo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One idle cycle loads shadows and select, then enable rises
    task automatic start(input logic [7:0] d, input logic [7:0] p, input logic s);
        enable  = 1'b0;
        duty    = d;
        periodo = p;
        sel_req = s;
        tick();
        enable  = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; duty = 8'd3; periodo = 8'd9; sel_req = 1'b1;
        tick();
        tick();
        checks++; if (signal_conmutacion !== 1'b0) begin errors++; $display("FAIL reset_sig got %b exp 0", signal_conmutacion); end
        checks++; if (select_salida !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", select_salida); end
        checks++; if (cambio_en_curso !== 1'b0) begin errors++; $display("FAIL reset_cambio got %b exp 0", cambio_en_curso); end
        checks++; if (fin_periodo !== 1'b0) begin errors++; $display("FAIL reset_fin got %b exp 0", fin_periodo); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic es, ef;
        start(8'd3, 8'd9, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            es = (((k - 1) % 10) < 3);
            ef = ((k % 10) == 0);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL basic_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            checks++; if (fin_periodo !== ef) begin errors++; $display("FAIL basic_fin k=%0d got %b exp %b", k, fin_periodo, ef); end
            checks++; if (cambio_en_curso !== 1'b0) begin errors++; $display("FAIL basic_cambio k=%0d got %b exp 0", k, cambio_en_curso); end
        end
    endtask

    // Continues from test_basic: counter is at 0 after cycle 30
    task automatic test_duty_change;
        logic es;
        int   d;
        for (int k = 31; k <= 50; k++) begin
            tick();
            d  = (k <= 40) ? 3 : 7;
            es = (((k - 1) % 10) < d);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL duty_change_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            if (k == 34) duty = 8'd7;
        end
    endtask

    task automatic test_full_duty;
        logic es;
        start(8'd0, 8'd9, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            es = (k >= 21);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL full_duty_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            if (k == 15) duty = 8'd12;
        end
    endtask

    task automatic test_period_zero;
        start(8'd1, 8'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (signal_conmutacion !== 1'b1) begin errors++; $display("FAIL p0_d1_sig k=%0d got %b exp 1", k, signal_conmutacion); end
            checks++; if (fin_periodo !== 1'b1) begin errors++; $display("FAIL p0_d1_fin k=%0d got %b exp 1", k, fin_periodo); end
        end
        start(8'd0, 8'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (signal_conmutacion !== 1'b0) begin errors++; $display("FAIL p0_d0_sig k=%0d got %b exp 0", k, signal_conmutacion); end
            checks++; if (fin_periodo !== 1'b1) begin errors++; $display("FAIL p0_d0_fin k=%0d got %b exp 1", k, fin_periodo); end
        end
    endtask

    task automatic test_idle;
        logic [3:0] pat;
        pat    = 4'b0101;
        enable = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            sel_req = pat[k];
            tick();
            checks++; if (select_salida !== pat[k]) begin errors++; $display("FAIL idle_sel k=%0d got %b exp %b", k, select_salida, pat[k]); end
            checks++; if (signal_conmutacion !== 1'b0) begin errors++; $display("FAIL idle_sig k=%0d got %b exp 0", k, signal_conmutacion); end
            checks++; if (fin_periodo !== 1'b0) begin errors++; $display("FAIL idle_fin k=%0d got %b exp 0", k, fin_periodo); end
        end
    endtask

    task automatic test_changeover;
        logic es, ef, ec, esel;
        int   j;
        start(8'd5, 8'd9, 1'b0);
`ifdef GENERADOR_TIEMPO_MUERTO_EN
        for (int k = 1; k <= 56; k++) begin
            tick();
            if (k <= 19) begin
                es = (((k - 1) % 10) < 5); ef = (k == 10); ec = 1'b0; esel = 1'b0;
            end else if (k <= 35) begin
                es = 1'b0; ef = (k == 20); ec = 1'b1; esel = 1'b0;
            end else if (k == 36) begin
                es = 1'b0; ef = 1'b0; ec = 1'b0; esel = 1'b1;
            end else begin
                j  = k - 36;
                es = (((j - 1) % 10) < 5); ef = ((j % 10) == 0); ec = 1'b0; esel = 1'b1;
            end
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL chg_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            checks++; if (fin_periodo !== ef) begin errors++; $display("FAIL chg_fin k=%0d got %b exp %b", k, fin_periodo, ef); end
            checks++; if (cambio_en_curso !== ec) begin errors++; $display("FAIL chg_cambio k=%0d got %b exp %b", k, cambio_en_curso, ec); end
            checks++; if (select_salida !== esel) begin errors++; $display("FAIL chg_sel k=%0d got %b exp %b", k, select_salida, esel); end
            if (k == 13) sel_req = 1'b1;
        end
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            es   = (((k - 1) % 10) < 5);
            ef   = ((k % 10) == 0);
            esel = (k >= 20);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL chg_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            checks++; if (fin_periodo !== ef) begin errors++; $display("FAIL chg_fin k=%0d got %b exp %b", k, fin_periodo, ef); end
            checks++; if (cambio_en_curso !== 1'b0) begin errors++; $display("FAIL chg_cambio k=%0d got %b exp 0", k, cambio_en_curso); end
            checks++; if (select_salida !== esel) begin errors++; $display("FAIL chg_sel k=%0d got %b exp %b", k, select_salida, esel); end
            if (k == 13) sel_req = 1'b1;
        end
`endif
    endtask

`ifndef GENERADOR_TIEMPO_MUERTO_EN
    // Constant-high output exposes the single forced-low changeover cycle
    task automatic test_forced_low;
        logic es, esel;
        start(8'd12, 8'd9, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            es   = (k != 10);
            esel = (k >= 10);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL forced_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            checks++; if (select_salida !== esel) begin errors++; $display("FAIL forced_sel k=%0d got %b exp %b", k, select_salida, esel); end
            if (k == 5) sel_req = 1'b1;
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic es, ef;
        start(8'd5, 8'd9, 1'b1);
`ifdef GENERADOR_TIEMPO_MUERTO_EN
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k >= 10) begin
                checks++; if (cambio_en_curso !== 1'b1) begin errors++; $display("FAIL rmid_cambio k=%0d got %b exp 1", k, cambio_en_curso); end
            end
            if (k == 3) sel_req = 1'b0;
        end
`else
        for (int k = 1; k <= 4; k++) tick();
`endif
        reset = 1'b1;
        tick();
        checks++; if (signal_conmutacion !== 1'b0) begin errors++; $display("FAIL rmid_sig got %b exp 0", signal_conmutacion); end
        checks++; if (select_salida !== 1'b0) begin errors++; $display("FAIL rmid_sel got %b exp 0", select_salida); end
        checks++; if (cambio_en_curso !== 1'b0) begin errors++; $display("FAIL rmid_cambio got %b exp 0", cambio_en_curso); end
        checks++; if (fin_periodo !== 1'b0) begin errors++; $display("FAIL rmid_fin got %b exp 0", fin_periodo); end
        reset   = 1'b0;
        sel_req = 1'b0;
        tick();
        checks++; if (signal_conmutacion !== 1'b0) begin errors++; $display("FAIL rrel_sig got %b exp 0", signal_conmutacion); end
        checks++; if (fin_periodo !== 1'b0) begin errors++; $display("FAIL rrel_fin got %b exp 0", fin_periodo); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            es = (((k - 1) % 10) < 5);
            ef = (k == 10);
            checks++; if (signal_conmutacion !== es) begin errors++; $display("FAIL rrel_sig k=%0d got %b exp %b", k, signal_conmutacion, es); end
            checks++; if (fin_periodo !== ef) begin errors++; $display("FAIL rrel_fin k=%0d got %b exp %b", k, fin_periodo, ef); end
            checks++; if (select_salida !== 1'b0) begin errors++; $display("FAIL rrel_sel k=%0d got %b exp 0", k, select_salida); end
            checks++; if (cambio_en_curso !== 1'b0) begin errors++; $display("FAIL rrel_cambio k=%0d got %b exp 0", k, cambio_en_curso); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_full_duty();
        test_period_zero();
        test_idle();
        test_changeover();
`ifndef GENERADOR_TIEMPO_MUERTO_EN
        test_forced_low();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
